// File: rtl/serial_tx.sv
// serial_tx: byte-serial UART transmitter. Sends 8 data bits LSB first,
// with optional parity and 1 or 2 stop bits. The line idles high.
//   clk      : system clock, rising edge
//   rst      : synchronous active-high reset
//   block    : external hold-off; keeps busy high and stops new frames
//   data     : byte to send, sampled on the accepting edge only
//   new_data : one-cycle request strobe (dropped if not accepted)
//   busy     : registered; frame in flight or block was high
//   tx       : registered serial output
module serial_tx #(
  parameter int CLK_PER_BIT = 50,
  parameter int PARITY      = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       block,
  input  logic [7:0] data,
  input  logic       new_data,
  output logic       busy,
  output logic       tx
);

  localparam int unsigned CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(CLK_PER_BIT - 1);
  localparam bit PAR_EN  = (PARITY == 1) || (PARITY == 2);
  localparam bit PAR_ODD = (PARITY == 1);
  localparam logic [2:0] STOP_LAST = (STOP_BITS == 2) ? 3'd1 : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          bit_end;
  logic          accept;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    tx_d    = tx_q;
    bit_end = (cnt_q == CNT_MAX);
    accept  = new_data && (state_q == S_IDLE) && !busy_q && !block;

    if (state_q != S_IDLE) begin
      cnt_d = bit_end ? '0 : cnt_q + CW'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = S_START;
          cnt_d   = '0;
          bit_d   = '0;
          shift_d = data;
          // parity latched with the byte since the shift register is consumed
          par_d   = PAR_ODD ? ~^data : ^data;
          tx_d    = 1'b0;
        end
      end
      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          tx_d    = shift_q[0];
        end
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
            bit_d = '0;
            if (PAR_EN) begin
              state_d = S_PARITY;
              tx_d    = par_q;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
            end
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
            tx_d    = shift_q[1];
          end
        end
      end
      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
        end
      end
      S_STOP: begin
        // bit counter reused to count stop bits
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            state_d = S_IDLE;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase

    busy_d = (state_d != S_IDLE) || block;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign tx   = tx_q;

endmodule

// File: tb/tb_serial_tx.sv
module tb_serial_tx;

  localparam int C    = 4;
  localparam int NCFG = 4;
  localparam int PARS [NCFG] = '{0, 1, 2, 2};
  localparam int STPS [NCFG] = '{1, 1, 1, 2};

  typedef struct {
    int          acc;
    logic [11:0] bits;
    int          nbits;
  } frame_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            block = 1'b0;
  logic            new_data = 1'b0;
  logic [7:0]      data = 8'h00;
  logic [NCFG-1:0] busy_w;
  logic [NCFG-1:0] tx_w;

  int cyc    = 0;
  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int inst,
                     input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d @cycle %0d: got %0h, expected %0h",
               name, inst, cyc, act, exp);
    end
  endtask

  // Expected line levels, one entry per bit time.
  function automatic frame_t mk_frame(input int acc, input logic [7:0] b,
                                      input int par, input int stp);
    frame_t f;
    int     n;
    logic   ones_odd;
    f.bits    = '1;
    f.bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) f.bits[i+1] = b[i];
    n = 9;
    ones_odd = ($countones(b) % 2) == 1;
    if (par == 1) begin
      f.bits[n] = !ones_odd;   // total ones including parity is odd
      n++;
    end else if (par == 2) begin
      f.bits[n] = ones_odd;    // total ones including parity is even
      n++;
    end
    n += (stp == 2) ? 2 : 1;
    f.nbits = n;
    f.acc   = acc;
    return f;
  endfunction

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int PAR = PARS[g];
    localparam int STP = STPS[g];
    localparam int T   = C * (9 + ((PAR == 1 || PAR == 2) ? 1 : 0) + ((STP == 2) ? 2 : 1));

    frame_t q[$];
    frame_t cur;
    int     acc    = 0;
    bit     act    = 1'b0;
    bit     busy_m = 1'b0;
    bit     flush  = 1'b0;
    bit     cap    = 1'b0;
    int     ccnt   = 0;

    serial_tx #(.CLK_PER_BIT(C), .PARITY(PAR), .STOP_BITS(STP)) u_dut (
      .clk     (clk),
      .rst     (rst),
      .block   (block),
      .data    (data),
      .new_data(new_data),
      .busy    (busy_w[g]),
      .tx      (tx_w[g])
    );

    // Reference model: decides acceptance from frame timing and queues
    // the expected frame.
    always @(posedge clk) begin
      bit idle_before;
      if (rst) begin
        act    = 1'b0;
        busy_m = 1'b0;
        q.delete();
        flush  = 1'b1;
      end else begin
        idle_before = !(act && (cyc - 1 - acc) < T);
        if (new_data && idle_before && !busy_m && !block) begin
          acc = cyc;
          act = 1'b1;
          q.push_back(mk_frame(cyc, data, PAR, STP));
        end
        busy_m = (act && (cyc - acc) < T) || block;
      end
    end

    // Monitor: compares the line against queued frames.
    always @(negedge clk) begin
      if (flush) begin
        cap   = 1'b0;
        flush = 1'b0;
      end
      chk("busy", g, 32'(busy_w[g]), 32'(busy_m));
      if (!cap && q.size() > 0 && q[0].acc == cyc - 1) begin
        cur  = q.pop_front();
        cap  = 1'b1;
        ccnt = 0;
      end
      if (cap) begin
        chk("tx_bit", g, 32'(tx_w[g]), 32'(cur.bits[ccnt / C]));
        ccnt++;
        if (ccnt == cur.nbits * C) cap = 1'b0;
      end else begin
        chk("tx_idle", g, 32'(tx_w[g]), 32'd1);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b);
    data     = b;
    new_data = 1'b1;
    tick(1);
    new_data = 1'b0;
    data     = 8'($urandom);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(20);

    send(8'h30);
    tick(60);
    send(8'h31);
    tick(60);

    // requests during a frame are dropped
    send(8'h30);
    tick(3);
    send(8'h55);
    tick(14);
    send(8'h55);
    n = 0;
    while (busy_w[0] !== 1'b0 && n < 100) begin
      tick(1);
      n++;
    end
    chk("wait_idle", 0, 32'(n < 100), 32'd1);
    send(8'h31);
    tick(60);

    // block in idle, including rising together with new_data
    block    = 1'b1;
    data     = 8'hAA;
    new_data = 1'b1;
    tick(1);
    new_data = 1'b0;
    tick(3);
    send(8'h77);
    block = 1'b0;
    tick(3);

    // block raised mid-frame
    send(8'h5A);
    tick(10);
    block = 1'b1;
    tick(50);
    block = 1'b0;
    tick(5);

    // reset during data bit 3
    send(8'h30);
    tick(16);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    send(8'h30);
    tick(60);

    repeat (600) begin
      new_data = ($urandom_range(0, 5) == 0);
      data     = 8'($urandom);
      if ($urandom_range(0, 29) == 0) block = ~block;
      rst      = ($urandom_range(0, 399) == 0);
      tick(1);
    end
    rst      = 1'b0;
    new_data = 1'b0;
    block    = 1'b0;
    tick(60);

    chk("drain", 0, 32'(g_cfg[0].q.size()) + 32'(g_cfg[0].cap), 32'd0);
    chk("drain", 1, 32'(g_cfg[1].q.size()) + 32'(g_cfg[1].cap), 32'd0);
    chk("drain", 2, 32'(g_cfg[2].q.size()) + 32'(g_cfg[2].cap), 32'd0);
    chk("drain", 3, 32'(g_cfg[3].q.size()) + 32'(g_cfg[3].cap), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
